// File: rtl/servo_pulse_decoder.sv
// servo_pulse_decoder
//   Measures the high time of an incoming RC servo pulse and recovers the
//   8-bit position byte d = min(255, round((max(W, OFFSET) - OFFSET) / STEP)).
//   Pulses outside [MIN_WIDTH, MAX_WIDTH] are rejected. A level flag reports
//   loss of signal when no rising edge has been seen for TIMEOUT cycles.
//
// Ports
//   clk           in   system clock
//   rst           in   asynchronous, active-high reset
//   RCServo_pulse in   servo pulse, asynchronous to clk
//   pos_data      out  [7:0] last decoded position, held between updates
//   pos_valid     out  one-cycle strobe when pos_data updates
//   pulse_err     out  one-cycle strobe when a measured pulse is rejected
//   signal_lost   out  no rising edge for TIMEOUT cycles; cleared by pos_valid
module servo_pulse_decoder #(
    parameter int unsigned OFFSET    = 25000,
    parameter int unsigned STEP      = 320,
    parameter int unsigned MIN_WIDTH = 20000,
    parameter int unsigned MAX_WIDTH = 120000,
    parameter int unsigned TIMEOUT   = 1600000,
    parameter int unsigned CNT_W     = 17
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RCServo_pulse,
    output logic [7:0] pos_data,
    output logic       pos_valid,
    output logic       pulse_err,
    output logic       signal_lost
);

    localparam int unsigned R_W  = CNT_W + 1;
    localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

    localparam logic [R_W-1:0]   OFF_R  = R_W'(OFFSET);
    localparam logic [R_W-1:0]   STEP_R = R_W'(STEP);
    localparam logic [R_W-1:0]   HALF_R = R_W'(STEP / 2);
    localparam logic [CNT_W-1:0] MIN_W  = CNT_W'(MIN_WIDTH);
    localparam logic [CNT_W-1:0] MAX_W  = CNT_W'(MAX_WIDTH);
    localparam logic [TO_W-1:0]  TO_MAX = TO_W'(TIMEOUT);

    typedef enum logic [1:0] {
        ARM,
        WAIT_RISE,
        MEASURE,
        DIVIDE
    } state_t;

    state_t           state_q, state_d;
    logic             sync1_q, sync2_q, sdel_q;
    logic [CNT_W-1:0] wcnt_q, wcnt_d;
    logic [TO_W-1:0]  tocnt_q, tocnt_d;
    logic [R_W-1:0]   rem_q, rem_d;
    logic [7:0]       quo_q, quo_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic             lost_q, lost_d;

    logic rise, fall, range_ok, div_step;

    assign rise     = sync2_q & ~sdel_q;
    assign fall     = ~sync2_q & sdel_q;
    assign range_ok = (wcnt_q >= MIN_W) && (wcnt_q <= MAX_W);
    assign div_step = (rem_q >= STEP_R) && (quo_q != 8'hFF);

    // Synchronizer and delay flop reset to "high": a pulse already high when
    // reset releases then never shows a rise, so ARM waits for a real low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            sdel_q  <= 1'b1;
        end else begin
            sync1_q <= RCServo_pulse;
            sync2_q <= sync1_q;
            sdel_q  <= sync2_q;
        end
    end

    // Width counter loads 1 on rise so that the rise cycle itself is counted
    // and the value seen at fall is the full high-cycle count.
    always_comb begin
        wcnt_d = wcnt_q;
        if (rise)
            wcnt_d = CNT_W'(1);
        else if (sync2_q && (wcnt_q != '1))
            wcnt_d = wcnt_q + CNT_W'(1);

        tocnt_d = tocnt_q;
        if (rise)
            tocnt_d = '0;
        else if (tocnt_q != TO_MAX)
            tocnt_d = tocnt_q + TO_W'(1);
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= ARM;
        else
            state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ARM:       if (!sync2_q) state_d = WAIT_RISE;
            WAIT_RISE: if (rise)     state_d = MEASURE;
            MEASURE:   if (fall)     state_d = range_ok ? DIVIDE : WAIT_RISE;
            DIVIDE:    if (!div_step) state_d = WAIT_RISE;
            default:   state_d = ARM;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        rem_d   = rem_q;
        quo_d   = quo_q;
        data_d  = data_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            MEASURE: begin
                if (fall) begin
                    if (!range_ok) begin
                        err_d = 1'b1;
                    end else begin
                        quo_d = '0;
                        if ({1'b0, wcnt_q} <= OFF_R)
                            rem_d = HALF_R;
                        else
                            rem_d = {1'b0, wcnt_q} - OFF_R + HALF_R;
                    end
                end
            end
            DIVIDE: begin
                if (div_step) begin
                    rem_d = rem_q - STEP_R;
                    quo_d = quo_q + 8'd1;
                end else begin
                    data_d  = quo_q;
                    valid_d = 1'b1;
                end
            end
            default: ;
        endcase

        // A successful decode clears loss-of-signal; rejected pulses do not.
        lost_d = lost_q;
        if (valid_d)
            lost_d = 1'b0;
        else if (tocnt_d == TO_MAX)
            lost_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt_q  <= '0;
            tocnt_q <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            lost_q  <= 1'b0;
        end else begin
            wcnt_q  <= wcnt_d;
            tocnt_q <= tocnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            lost_q  <= lost_d;
        end
    end

    assign pos_data    = data_q;
    assign pos_valid   = valid_q;
    assign pulse_err   = err_q;
    assign signal_lost = lost_q;

endmodule

// File: tb/tb_servo_pulse_decoder.sv
// Directed bench for servo_pulse_decoder with time-scaled parameters:
// OFFSET=250, STEP=4, MIN=200, MAX=1300, TIMEOUT=4000, 11-bit width counter.
// Expected decode: d = min(255, floor((max(W,250) - 250 + 2) / 4)).
// Latency (negedges after the input is driven low): pulse_err 3, pos_valid 4+d.
module tb_servo_pulse_decoder;

    localparam int unsigned OFFSET    = 250;
    localparam int unsigned STEP      = 4;
    localparam int unsigned MIN_WIDTH = 200;
    localparam int unsigned MAX_WIDTH = 1300;
    localparam int unsigned TIMEOUT   = 4000;
    localparam int unsigned CNT_W     = 11;

    logic       clk = 1'b0;
    logic       rst;
    logic       pulse;
    logic [7:0] pos_data;
    logic       pos_valid;
    logic       pulse_err;
    logic       signal_lost;

    int checks   = 0;
    int failures = 0;
    int nvalid   = 0;
    int nerr     = 0;
    int both     = 0;
    int data_bad = 0;
    logic [7:0] prev_data = '0;

    int lat_v, lat_e, v0, e0;
    logic lost_at_v, lost_pre_v, lost_prev;

    servo_pulse_decoder #(
        .OFFSET   (OFFSET),
        .STEP     (STEP),
        .MIN_WIDTH(MIN_WIDTH),
        .MAX_WIDTH(MAX_WIDTH),
        .TIMEOUT  (TIMEOUT),
        .CNT_W    (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .RCServo_pulse(pulse),
        .pos_data     (pos_data),
        .pos_valid    (pos_valid),
        .pulse_err    (pulse_err),
        .signal_lost  (signal_lost)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (pos_valid) nvalid <= nvalid + 1;
            if (pulse_err) nerr <= nerr + 1;
            if (pos_valid && pulse_err) both <= both + 1;
            if (!pos_valid && (pos_data !== prev_data)) data_bad <= data_bad + 1;
        end
        prev_data <= pos_data;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive one high pulse of w cycles, then hold low for gap cycles while
    // recording first strobe latencies and signal_lost around pos_valid.
    task automatic frame(input int w, input int gap);
        @(negedge clk);
        pulse = 1'b1;
        repeat (w) @(negedge clk);
        pulse = 1'b0;
        lat_v = 0;
        lat_e = 0;
        lost_at_v  = 1'bx;
        lost_pre_v = 1'bx;
        lost_prev  = signal_lost;
        for (int k = 1; k <= gap; k++) begin
            @(negedge clk);
            if (pos_valid && lat_v == 0) begin
                lat_v      = k;
                lost_at_v  = signal_lost;
                lost_pre_v = lost_prev;
            end
            if (pulse_err && lat_e == 0) lat_e = k;
            lost_prev = signal_lost;
        end
        #1;
    endtask

    initial begin
        rst   = 1'b1;
        pulse = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_pos_data", pos_data, 0);
        chk("rst_pos_valid", pos_valid, 0);
        chk("rst_pulse_err", pulse_err, 0);
        chk("rst_signal_lost", signal_lost, 0);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // Nominal sweep d = 0, 1, 128, 255
        v0 = nvalid; e0 = nerr;
        frame(250, 400);  chk("d0_data", pos_data, 0);     chk("d0_lat", lat_v, 4);
        frame(254, 400);  chk("d1_data", pos_data, 1);     chk("d1_lat", lat_v, 5);
        frame(762, 400);  chk("d128_data", pos_data, 128); chk("d128_lat", lat_v, 132);
        frame(1270, 400); chk("d255_data", pos_data, 255); chk("d255_lat", lat_v, 259);
        chk("sweep_valids", nvalid - v0, 4);
        chk("sweep_errs", nerr - e0, 0);

        // Rounding and clamping
        frame(251, 400);  chk("round_down", pos_data, 0);
        frame(252, 400);  chk("round_up", pos_data, 1);
        frame(240, 400);  chk("below_offset", pos_data, 0);
        frame(1300, 400); chk("clamp_data", pos_data, 255); chk("clamp_lat", lat_v, 259);

        // Rejects, including both range edges and counter saturation
        v0 = nvalid; e0 = nerr;
        frame(5, 400);    chk("glitch_err_lat", lat_e, 3); chk("glitch_no_valid", lat_v, 0);
        chk("glitch_data_held", pos_data, 255);
        frame(1400, 400); chk("wide_err_lat", lat_e, 3);
        frame(199, 400);  chk("min_minus1_err", lat_e, 3);
        frame(1301, 400); chk("max_plus1_err", lat_e, 3);
        frame(2100, 400); chk("saturate_err", lat_e, 3);
        chk("reject_errs", nerr - e0, 5);
        chk("reject_valids", nvalid - v0, 0);
        frame(762, 400);  chk("recover_data", pos_data, 128); chk("recover_lat", lat_v, 132);
        frame(200, 400);  chk("min_edge_data", pos_data, 0); chk("min_edge_lat", lat_v, 4);

        // Timeout: lost rises TIMEOUT+3 negedges after the input rise
        chk("lost_before", signal_lost, 0);
        @(negedge clk);
        pulse = 1'b1;
        repeat (762) @(negedge clk);
        pulse = 1'b0;
        repeat (TIMEOUT + 2 - 762) @(negedge clk);
        chk("lost_early", signal_lost, 0);
        @(negedge clk);
        chk("lost_set", signal_lost, 1);
        chk("lost_data", pos_data, 128);
        frame(5, 400);    chk("lost_glitch_err", lat_e, 3); chk("lost_after_glitch", signal_lost, 1);
        frame(254, 400);  chk("lost_clear_data", pos_data, 1); chk("lost_clear_lat", lat_v, 5);
        chk("lost_pre_valid", lost_pre_v, 1);
        chk("lost_at_valid", lost_at_v, 0);

        // Reset during a high pulse, released while still high
        v0 = nvalid; e0 = nerr;
        @(negedge clk);
        pulse = 1'b1;
        repeat (100) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrst_data", pos_data, 0);
        rst = 1'b0;
        repeat (300) @(negedge clk);
        pulse = 1'b0;
        repeat (400) @(negedge clk);
        #1;
        chk("midrst_no_valid", nvalid - v0, 0);
        chk("midrst_no_err", nerr - e0, 0);
        frame(762, 400);  chk("midrst_next_data", pos_data, 128); chk("midrst_next_lat", lat_v, 132);

        // Rise 100 cycles after a d=255 fall lands inside DIVIDE and is skipped
        v0 = nvalid; e0 = nerr;
        frame(1270, 100);
        frame(762, 400);
        chk("skip_valids", nvalid - v0, 1);
        chk("skip_errs", nerr - e0, 0);
        chk("skip_data", pos_data, 255);
        frame(254, 400);  chk("skip_third_data", pos_data, 1); chk("skip_third_lat", lat_v, 5);

        chk("never_both_strobes", both, 0);
        chk("data_only_on_valid", data_bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
